// File: rtl/portal_pkg.sv
// Shared portal types: header/message layouts and the assembler state encoding.
package portal_pkg;

  typedef struct packed {
    logic [15:0] meth_id;
    logic [15:0] count;
  } portal_hdr_t;

  typedef struct packed {
    logic [31:0] tag;
    logic [31:0] meth;
    logic [31:0] v;
  } portal_msg_t;

  typedef enum logic [1:0] {
    HDR   = 2'd0,
    PAY   = 2'd1,
    DRAIN = 2'd2,
    FULL  = 2'd3
  } asm_state_t;

  localparam int PORTAL_HEARD_TAG = 1;

endpackage

// File: rtl/portal_msg_assembler_if.sv
// Word-in / message-out handshake bundle for the portal message assembler.
interface portal_msg_assembler_if;
  import portal_pkg::*;

  logic        word_enq__ENA;
  logic [31:0] word_enq_v;
  logic        word_enq__RDY;
  logic        pipe_enq__ENA;
  portal_msg_t pipe_enq_v;
  logic        pipe_enq__RDY;

  // slave = assembler side, master = word source / message sink side
  modport slave (
    input  word_enq__ENA, word_enq_v, pipe_enq__RDY,
    output word_enq__RDY, pipe_enq__ENA, pipe_enq_v
  );

  modport master (
    output word_enq__ENA, word_enq_v, pipe_enq__RDY,
    input  word_enq__RDY, pipe_enq__ENA, pipe_enq_v
  );

endinterface

// File: rtl/sat_counter32.sv
// 32-bit event counter that sticks at all-ones; synchronous clear has priority.
module sat_counter32 (
  input  logic        CLK,
  input  logic        clr,
  input  logic        inc,
  output logic [31:0] count
);

  always_ff @(posedge CLK) begin
    if (clr)
      count <= '0;
    else if (inc && (count != 32'hFFFF_FFFF))
      count <= count + 32'd1;
  end

endmodule

// File: rtl/portal_msg_assembler.sv
// Assembles header + payload portal words into one {tag, meth, v} message.
// Optional statistics outputs are enabled by defining PORTAL_ASM_STATS_EN.
module portal_msg_assembler
  import portal_pkg::*;
#(
  parameter int MAX_WORDS = 16,
  parameter int CNT_W     = 16
) (
  input  logic                   CLK,
  input  logic                   nRST,
  portal_msg_assembler_if.slave  bus,
`ifdef PORTAL_ASM_STATS_EN
  output logic [31:0]            msg_count,
  output logic [31:0]            drop_count,
`endif
  output logic                   drop_pulse
);

  localparam logic [CNT_W-1:0] MAX_N   = CNT_W'(MAX_WORDS);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  asm_state_t       state_p0, state_nxt;
  logic [CNT_W-1:0] cnt_p0,   cnt_nxt;
  logic [CNT_W-1:0] num_p0,   num_nxt;
  portal_msg_t      msg_p0,   msg_nxt;
  logic             drop_p0,  drop_nxt;

  portal_hdr_t      hdr;
  logic [CNT_W-1:0] hdr_n;
  logic             word_acc;
  logic             last_word;
  logic             pipe_xfer;

  assign hdr       = portal_hdr_t'(bus.word_enq_v);
  assign hdr_n     = CNT_W'(hdr.count);
  assign word_acc  = bus.word_enq__ENA && (state_p0 != FULL);
  // The counter never exceeds N-1, so N=all-ones drains without wrapping.
  assign last_word = (cnt_p0 == (num_p0 - CNT_ONE));
  assign pipe_xfer = (state_p0 == FULL) && bus.pipe_enq__RDY;

  always_comb begin
    state_nxt = state_p0;
    cnt_nxt   = cnt_p0;
    num_nxt   = num_p0;
    msg_nxt   = msg_p0;
    drop_nxt  = 1'b0;
    case (state_p0)
      HDR: begin
        if (word_acc) begin
          msg_nxt.tag  = {16'h0000, hdr.meth_id + 16'(PORTAL_HEARD_TAG)};
          msg_nxt.meth = '0;
          msg_nxt.v    = '0;
          num_nxt      = hdr_n;
          cnt_nxt      = '0;
          if (hdr_n == '0)
            state_nxt = FULL;
          else if (hdr_n > MAX_N)
            state_nxt = DRAIN;
          else
            state_nxt = PAY;
        end
      end
      PAY: begin
        if (word_acc) begin
          if (cnt_p0 == '0)
            msg_nxt.meth = bus.word_enq_v;
          if (cnt_p0 == CNT_ONE)
            msg_nxt.v = bus.word_enq_v;
          if (last_word) begin
            cnt_nxt   = '0;
            state_nxt = FULL;
          end else begin
            cnt_nxt = cnt_p0 + CNT_ONE;
          end
        end
      end
      DRAIN: begin
        if (word_acc) begin
          if (last_word) begin
            cnt_nxt   = '0;
            drop_nxt  = 1'b1;
            state_nxt = HDR;
          end else begin
            cnt_nxt = cnt_p0 + CNT_ONE;
          end
        end
      end
      FULL: begin
        if (bus.pipe_enq__RDY)
          state_nxt = HDR;
      end
      default: state_nxt = HDR;
    endcase
  end

  // Stage p0: FSM state, word counter, held message and drop pulse
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_p0 <= HDR;
      cnt_p0   <= '0;
      num_p0   <= '0;
      msg_p0   <= '0;
      drop_p0  <= 1'b0;
    end else begin
      state_p0 <= state_nxt;
      cnt_p0   <= cnt_nxt;
      num_p0   <= num_nxt;
      msg_p0   <= msg_nxt;
      drop_p0  <= drop_nxt;
    end
  end

  assign bus.word_enq__RDY = (state_p0 != FULL);
  assign bus.pipe_enq__ENA = (state_p0 == FULL);
  assign bus.pipe_enq_v    = msg_p0;
  assign drop_pulse        = drop_p0;

`ifdef PORTAL_ASM_STATS_EN
  sat_counter32 u_msg_cnt (
    .CLK   (CLK),
    .clr   (!nRST),
    .inc   (pipe_xfer),
    .count (msg_count)
  );

  sat_counter32 u_drop_cnt (
    .CLK   (CLK),
    .clr   (!nRST),
    .inc   (drop_p0),
    .count (drop_count)
  );
`else
  logic unused_xfer;
  assign unused_xfer = pipe_xfer;
`endif

endmodule

// File: tb/tb_portal_msg_assembler.sv
// Directed + randomized bench for portal_msg_assembler against a message-level reference model.
module tb_portal_msg_assembler;
  import portal_pkg::*;

  localparam int MAX_WORDS = 16;

  logic CLK = 1'b0;
  logic nRST;
  logic drop_pulse;
`ifdef PORTAL_ASM_STATS_EN
  logic [31:0] msg_count;
  logic [31:0] drop_count;
`endif

  int n_cmp = 0;
  int n_err = 0;

  logic        dir_rdy;
  logic        rand_rdy;
  logic        rnd_bit;
  logic [95:0] exp_q[$];
  logic [95:0] got_q[$];
  int          exp_drops;
  int          got_drops;
  logic        stall_prev;
  logic [95:0] prev_v;

  portal_msg_assembler_if bus ();

  portal_msg_assembler #(.MAX_WORDS(MAX_WORDS), .CNT_W(16)) dut (
    .CLK        (CLK),
    .nRST       (nRST),
    .bus        (bus),
`ifdef PORTAL_ASM_STATS_EN
    .msg_count  (msg_count),
    .drop_count (drop_count),
`endif
    .drop_pulse (drop_pulse)
  );

  always #5 CLK = ~CLK;

  assign bus.pipe_enq__RDY = rand_rdy ? rnd_bit : dir_rdy;

  always @(negedge CLK) rnd_bit = 1'($urandom_range(0, 1));

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Observes settled pre-edge values: records transfers and drops, checks hold stability
  always @(negedge CLK) begin
    #1;
    if (nRST) begin
      if (bus.pipe_enq__ENA) begin
        if (stall_prev) chk("hold_stable", bus.pipe_enq_v, prev_v);
        if (bus.pipe_enq__RDY) got_q.push_back(bus.pipe_enq_v);
      end
      if (drop_pulse) got_drops++;
      stall_prev = bus.pipe_enq__ENA && !bus.pipe_enq__RDY;
      prev_v     = bus.pipe_enq_v;
    end else begin
      stall_prev = 1'b0;
    end
  end

  // Called and returns at a negedge; word is accepted on the edge in between
  task automatic send_word(input logic [31:0] w);
    int guard;
    guard = 0;
    bus.word_enq__ENA = 1'b1;
    bus.word_enq_v    = w;
    while (!bus.word_enq__RDY && guard < 500) begin
      @(negedge CLK);
      guard++;
    end
    if (guard >= 500) chk("word_rdy_timeout", 96'(0), 96'(1));
    @(negedge CLK);
    bus.word_enq__ENA = 1'b0;
  endtask

  // Reference: message is {id+1, first payload, second payload} or a drop when N > MAX_WORDS
  task automatic send_msg(input logic [15:0] id, input int n);
    logic [31:0] p0, p1, w;
    p0 = '0;
    p1 = '0;
    send_word({id, 16'(n)});
    for (int i = 0; i < n; i++) begin
      w = $urandom;
      if (i == 0) p0 = w;
      if (i == 1) p1 = w;
      send_word(w);
    end
    if (n > MAX_WORDS) exp_drops++;
    else exp_q.push_back({16'h0000, id + 16'd1, p0, p1});
  endtask

  task automatic check_msgs(input string tag);
    logic [95:0] g, e;
    for (int i = 0; i < 400 && got_q.size() < exp_q.size(); i++) @(negedge CLK);
    repeat (2) @(negedge CLK);
    #2;
    chk({tag, "_count"}, 96'(got_q.size()), 96'(exp_q.size()));
    chk({tag, "_drops"}, 96'(got_drops), 96'(exp_drops));
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      chk({tag, "_msg"}, g, e);
    end
    exp_q.delete();
    got_q.delete();
    exp_drops = 0;
    got_drops = 0;
    @(negedge CLK);
  endtask

  initial begin
    nRST = 1'b0;
    dir_rdy = 1'b0;
    rand_rdy = 1'b0;
    bus.word_enq__ENA = 1'b0;
    bus.word_enq_v = '0;
    exp_drops = 0;
    got_drops = 0;
    stall_prev = 1'b0;
    prev_v = '0;
    repeat (3) @(negedge CLK);
    nRST = 1'b1;
    @(negedge CLK);
    chk("rst_word_rdy", 96'(bus.word_enq__RDY), 96'(1));
    chk("rst_pipe_ena", 96'(bus.pipe_enq__ENA), 96'(0));
    chk("rst_drop", 96'(drop_pulse), 96'(0));
    chk("rst_pipe_v", bus.pipe_enq_v, 96'(0));
`ifdef PORTAL_ASM_STATS_EN
    chk("rst_msg_count", 96'(msg_count), 96'(0));
    chk("rst_drop_count", 96'(drop_count), 96'(0));
`endif

    // Basic two-payload message, sink always ready
    dir_rdy = 1'b1;
    send_word(32'h0000_0002);
    send_word(32'h0000_1234);
    send_word(32'h0000_5678);
    chk("t1_latency_ena", 96'(bus.pipe_enq__ENA), 96'(1));
    exp_q.push_back({32'h1, 32'h1234, 32'h5678});
    check_msgs("t1");

    // Back-pressure: message held for 5 cycles
    dir_rdy = 1'b0;
    send_word(32'h0000_0002);
    send_word(32'h0000_1234);
    send_word(32'h0000_5678);
    for (int i = 0; i < 5; i++) begin
      chk("t2_hold_ena", 96'(bus.pipe_enq__ENA), 96'(1));
      chk("t2_hold_word_rdy", 96'(bus.word_enq__RDY), 96'(0));
      chk("t2_hold_v", bus.pipe_enq_v, {32'h1, 32'h1234, 32'h5678});
      @(negedge CLK);
    end
    dir_rdy = 1'b1;
    @(negedge CLK);
    chk("t2_after_word_rdy", 96'(bus.word_enq__RDY), 96'(1));
    chk("t2_after_ena", 96'(bus.pipe_enq__ENA), 96'(0));
    exp_q.push_back({32'h1, 32'h1234, 32'h5678});
    check_msgs("t2");

    // Zero-payload header
    send_word(32'h0003_0000);
    chk("t3_ena", 96'(bus.pipe_enq__ENA), 96'(1));
    chk("t3_v", bus.pipe_enq_v, {32'h4, 32'h0, 32'h0});
    exp_q.push_back({32'h4, 32'h0, 32'h0});
    check_msgs("t3");

    // Oversize message dropped, then a normal one
    send_word(32'h0000_0011);
    for (int i = 0; i < 17; i++) begin
      if (i == 16) chk("t4_no_early_drop", 96'(got_drops), 96'(0));
      send_word(32'hA000_0000 + 32'(i));
    end
    chk("t4_drop_pulse", 96'(drop_pulse), 96'(1));
    @(negedge CLK);
    chk("t4_drop_pulse_clear", 96'(drop_pulse), 96'(0));
    exp_drops = 1;
    send_msg(16'h0042, 1);
    check_msgs("t4");

    // Extra payload words ignored
    send_word(32'h0000_0004);
    send_word(32'hAAAA_AAAA);
    send_word(32'hBBBB_BBBB);
    send_word(32'hCCCC_CCCC);
    send_word(32'hDDDD_DDDD);
    chk("t5_ena", 96'(bus.pipe_enq__ENA), 96'(1));
    exp_q.push_back({32'h1, 32'hAAAA_AAAA, 32'hBBBB_BBBB});
    check_msgs("t5");

    // Reset mid-message discards the partial message
    send_word(32'h0000_0002);
    send_word(32'h1111_1111);
    nRST = 1'b0;
    repeat (2) @(negedge CLK);
    nRST = 1'b1;
    @(negedge CLK);
    chk("t6_rst_word_rdy", 96'(bus.word_enq__RDY), 96'(1));
    chk("t6_rst_ena", 96'(bus.pipe_enq__ENA), 96'(0));
    send_msg(16'h0007, 2);
    check_msgs("t6");
`ifdef PORTAL_ASM_STATS_EN
    chk("t6_msg_count", 96'(msg_count), 96'(1));
    chk("t6_drop_count", 96'(drop_count), 96'(0));
`endif

    // Random headers and payload lengths with random sink readiness
    rand_rdy = 1'b1;
    for (int m = 0; m < 40; m++)
      send_msg(16'($urandom), int'($urandom_range(0, MAX_WORDS + 4)));
    check_msgs("rnd");
    rand_rdy = 1'b0;
    dir_rdy = 1'b1;

    // Maximum count drains 65535 words, then the FSM is back at header
    send_word(32'h0000_FFFF);
    for (int i = 0; i < 65535; i++) send_word(32'h0);
    exp_drops = 1;
    send_msg(16'hFFFF, 2);
    check_msgs("big");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
